// File: rtl/rtg_controller.sv
// Random test-vector generation controller: Galois LFSR vector source with
// adaptive acceptance of vectors based on fault-detection feedback.
module rtg_controller #(
  parameter int               VEC_W      = 64,
  parameter logic [VEC_W-1:0] POLY       = VEC_W'(64'hD800000000000000),
  parameter logic [VEC_W-1:0] SEED       = VEC_W'(1),
  parameter int               NUM_FAULTS = 1474,
  parameter int               UT_LIMIT   = 1000,
  parameter int               COV_PCT    = 99,
  parameter int               INIT_EXP   = 2,
  localparam int              IDX_W      = $clog2(NUM_FAULTS + 1),
  localparam int              UT_W       = $clog2(UT_LIMIT + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             vec_valid,
  output logic [VEC_W-1:0] vec_data,
  input  logic             vec_ready,
  input  logic             det_valid,
  input  logic [IDX_W-1:0] det_index,
  input  logic             det_hit,
  input  logic             det_last,
  output logic             acc_valid,
  output logic [VEC_W-1:0] acc_data,
  output logic             busy,
  output logic             done,
  output logic             cov_met,
  output logic [UT_W-1:0]  ut_count,
  output logic [IDX_W-1:0] det_total
);

  localparam logic [VEC_W-1:0] SEED_EFF   = (SEED == '0) ? VEC_W'(1) : SEED;
  localparam int               INIT_SAT   = (INIT_EXP > NUM_FAULTS) ? NUM_FAULTS : INIT_EXP;
  localparam logic [63:0]      COV_TARGET = 64'(COV_PCT) * 64'(NUM_FAULTS);

  typedef enum logic [2:0] {IDLE, GEN, COLLECT, EVAL, MERGE, DONE} state_t;

  state_t            state_q;
  logic [VEC_W-1:0]  lfsr_q, cur_vec_q;
  logic [IDX_W-1:0]  exp_q, ct_q, nw_q, total_q;
  logic [UT_W-1:0]   ut_q;
  logic [NUM_FAULTS:0] at_q, ct_map_q;  // bit 0 unused: faults are 1-based
  logic              cov_q, vec_valid_q, acc_valid_q;

  logic [VEC_W-1:0]  lfsr_d;
  logic              idx_ok, beat_new;
  logic [IDX_W:0]    exp_half, exp_avg, exp_raw;
  logic [IDX_W-1:0]  exp_d, total_merge;
  logic              accept, cov_now, cov_merge, ut_at_limit;

  assign lfsr_d      = lfsr_q[0] ? ((lfsr_q >> 1) ^ POLY) : (lfsr_q >> 1);
  assign idx_ok      = (det_index != '0) && (det_index <= IDX_W'(NUM_FAULTS));
  assign beat_new    = det_valid && det_hit && idx_ok && !ct_map_q[det_index];

  assign exp_half    = {1'b0, exp_q} >> 1;
  assign exp_avg     = ({1'b0, ct_q} + {1'b0, exp_q}) >> 1;
  assign exp_raw     = (ct_q < exp_q) ? exp_half : exp_avg;
  assign exp_d       = (exp_raw > (IDX_W + 1)'(NUM_FAULTS)) ? IDX_W'(NUM_FAULTS) : exp_raw[IDX_W-1:0];
  assign accept      = (ct_q >= exp_d) && (nw_q != '0);

  assign total_merge = total_q + nw_q;
  assign cov_now     = (64'(total_q) * 64'd100) >= COV_TARGET;
  assign cov_merge   = (64'(total_merge) * 64'd100) >= COV_TARGET;
  assign ut_at_limit = (ut_q == UT_W'(UT_LIMIT));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lfsr_q      <= SEED_EFF;
      cur_vec_q   <= '0;
      exp_q       <= IDX_W'(INIT_SAT);
      ct_q        <= '0;
      nw_q        <= '0;
      total_q     <= '0;
      ut_q        <= '0;
      at_q        <= '0;
      ct_map_q    <= '0;
      cov_q       <= 1'b0;
      vec_valid_q <= 1'b0;
      acc_valid_q <= 1'b0;
    end else begin
      acc_valid_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q     <= GEN;
            ut_q        <= '0;
            total_q     <= '0;
            at_q        <= '0;
            cov_q       <= 1'b0;
            exp_q       <= IDX_W'(INIT_SAT);
            vec_valid_q <= 1'b1;
          end
        end
        GEN: begin
          if (vec_ready) begin
            lfsr_q      <= lfsr_d;
            cur_vec_q   <= lfsr_q;
            ut_q        <= ut_q + UT_W'(1);
            ct_map_q    <= '0;
            ct_q        <= '0;
            nw_q        <= '0;
            vec_valid_q <= 1'b0;
            state_q     <= COLLECT;
          end
        end
        COLLECT: begin
          if (det_valid) begin
            if (beat_new) begin
              ct_map_q[det_index] <= 1'b1;
              ct_q                <= ct_q + IDX_W'(1);
              if (!at_q[det_index]) nw_q <= nw_q + IDX_W'(1);
            end
            if (det_last) state_q <= EVAL;
          end
        end
        EVAL: begin
          exp_q <= exp_d;
          if (accept) begin
            state_q     <= MERGE;
            acc_valid_q <= 1'b1;
          end else begin
            cov_q <= cov_now;
            if (cov_now || ut_at_limit) begin
              state_q <= DONE;
            end else begin
              state_q     <= GEN;
              vec_valid_q <= 1'b1;
            end
          end
        end
        MERGE: begin
          at_q    <= at_q | ct_map_q;
          total_q <= total_merge;
          cov_q   <= cov_merge;
          if (cov_merge || ut_at_limit) begin
            state_q <= DONE;
          end else begin
            state_q     <= GEN;
            vec_valid_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign vec_valid = vec_valid_q;
  assign vec_data  = lfsr_q;
  assign acc_valid = acc_valid_q;
  assign acc_data  = cur_vec_q;
  assign busy      = (state_q != IDLE) && (state_q != DONE);
  assign done      = (state_q == DONE);
  assign cov_met   = cov_q;
  assign ut_count  = ut_q;
  assign det_total = total_q;

endmodule

// File: tb/tb_rtg_controller.sv
// Bench for rtg_controller: two configurations (large fault list with a short
// vector budget, and a 4-fault list with 75% target) checked against a set-based model.
module tb_rtg_controller;

  localparam int NF_A = 1474, UT_A = 3, COV_A = 99;
  localparam int NF_B = 4,    UT_B = 8, COV_B = 75;
  localparam logic [7:0] POLY8 = 8'hB8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start_a, start_b, vec_ready, det_valid, det_hit, det_last;
  logic [10:0] det_index;

  logic       a_vv, a_av, a_busy, a_done, a_cov;
  logic [7:0] a_vd, a_ad;
  logic [1:0] a_ut;
  logic [10:0] a_tot;
  logic       b_vv, b_av, b_busy, b_done, b_cov;
  logic [7:0] b_vd, b_ad;
  logic [3:0] b_ut;
  logic [2:0] b_tot;

  rtg_controller #(.VEC_W(8), .POLY(POLY8), .SEED(8'h01), .NUM_FAULTS(NF_A),
                   .UT_LIMIT(UT_A), .COV_PCT(COV_A), .INIT_EXP(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a),
    .vec_valid(a_vv), .vec_data(a_vd), .vec_ready(vec_ready),
    .det_valid(det_valid), .det_index(det_index), .det_hit(det_hit), .det_last(det_last),
    .acc_valid(a_av), .acc_data(a_ad), .busy(a_busy), .done(a_done),
    .cov_met(a_cov), .ut_count(a_ut), .det_total(a_tot)
  );

  rtg_controller #(.VEC_W(8), .POLY(POLY8), .SEED(8'h01), .NUM_FAULTS(NF_B),
                   .UT_LIMIT(UT_B), .COV_PCT(COV_B), .INIT_EXP(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b),
    .vec_valid(b_vv), .vec_data(b_vd), .vec_ready(vec_ready),
    .det_valid(det_valid), .det_index(det_index[2:0]), .det_hit(det_hit), .det_last(det_last),
    .acc_valid(b_av), .acc_data(b_ad), .busy(b_busy), .done(b_done),
    .cov_met(b_cov), .ut_count(b_ut), .det_total(b_tot)
  );

  int tests_run = 0, tests_failed = 0;
  int sel = 0;

  logic       o_vv, o_av, o_busy, o_done, o_cov;
  logic [7:0] o_vd, o_ad;
  int         o_ut, o_tot;
  always_comb begin
    if (sel == 1) begin
      o_vv = b_vv; o_av = b_av; o_busy = b_busy; o_done = b_done; o_cov = b_cov;
      o_vd = b_vd; o_ad = b_ad; o_ut = int'(b_ut); o_tot = int'(b_tot);
    end else begin
      o_vv = a_vv; o_av = a_av; o_busy = a_busy; o_done = a_done; o_cov = a_cov;
      o_vd = a_vd; o_ad = a_ad; o_ut = int'(a_ut); o_tot = int'(a_tot);
    end
  end

  // Reference model: fault sets as bit arrays, plain integer arithmetic
  logic [7:0] m_lfsr [2];
  int m_exp, m_total, m_utc, m_nf, m_ut, m_cov;
  bit m_at [2048];
  int bq [$];
  bit fin;

  function automatic logic [7:0] lfsr_step(input logic [7:0] x);
    return x[0] ? ((x >> 1) ^ POLY8) : (x >> 1);
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic pick(input int s);
    sel = s;
    m_nf  = (s == 1) ? NF_B : NF_A;
    m_ut  = (s == 1) ? UT_B : UT_A;
    m_cov = (s == 1) ? COV_B : COV_A;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; vec_ready = 1'b0;
    det_valid = 1'b0; det_hit = 1'b0; det_last = 1'b0; det_index = '0;
    step(); step();
    rst_n = 1'b1;
    m_lfsr[0] = 8'h01; m_lfsr[1] = 8'h01;
  endtask

  task automatic do_start();
    if (sel == 1) start_b = 1'b1; else start_a = 1'b1;
    step();
    start_a = 1'b0; start_b = 1'b0;
    m_exp = 2; m_total = 0; m_utc = 0;
    foreach (m_at[i]) m_at[i] = 1'b0;
  endtask

  // One vector: wait, optional stall (with stray det beats), handshake, beats from bq, outcome checks.
  task automatic do_vector(input int stall);
    int cnt, acc_cnt, ct, nw, expn;
    logic [7:0] vec, accd;
    bit stable, acc_exp, cov_exp;
    bit seen [2048];
    cnt = 0;
    while (!o_vv && cnt < 20) begin step(); cnt++; end
    tests_run++;
    if (!o_vv) begin
      tests_failed++;
      $display("FAIL vec_valid_timeout got 0 want 1");
      fin = 1'b1;
      return;
    end
    vec = o_vd;
    tests_run++;
    if (vec !== m_lfsr[sel]) begin
      tests_failed++;
      $display("FAIL vec_data got %02h want %02h", vec, m_lfsr[sel]);
    end
    stable = 1'b1;
    for (int i = 0; i < stall; i++) begin
      det_valid = 1'b1; det_hit = 1'b1; det_last = 1'b1; det_index = 11'($urandom_range(1, 4));
      step();
      if (o_vd !== vec || o_vv !== 1'b1) stable = 1'b0;
    end
    det_valid = 1'b0; det_hit = 1'b0; det_last = 1'b0;
    if (stall > 0) begin
      tests_run++;
      if (!stable) begin
        tests_failed++;
        $display("FAIL vec_stall_stable got %02h/%0b want %02h/1", o_vd, o_vv, vec);
      end
    end
    vec_ready = 1'b1; step(); vec_ready = 1'b0;
    m_lfsr[sel] = lfsr_step(m_lfsr[sel]);

    foreach (bq[i]) begin
      det_valid = 1'b1;
      det_hit   = (bq[i] >= 0);
      det_index = (bq[i] >= 0) ? 11'(bq[i]) : 11'($urandom_range(1, 4));
      det_last  = (i == bq.size() - 1);
      step();
      if (i != bq.size() - 1 && $urandom_range(0, 3) == 0) begin
        det_valid = 1'b0; step();
      end
    end
    if (bq.size() == 0) begin
      det_valid = 1'b1; det_hit = 1'b0; det_last = 1'b1; det_index = '0; step();
    end
    det_valid = 1'b0; det_hit = 1'b0; det_last = 1'b0;

    foreach (seen[i]) seen[i] = 1'b0;
    ct = 0; nw = 0;
    foreach (bq[i]) begin
      if (bq[i] > 0 && bq[i] <= m_nf && !seen[bq[i]]) begin
        seen[bq[i]] = 1'b1; ct++;
        if (!m_at[bq[i]]) nw++;
      end
    end
    expn = (ct < m_exp) ? m_exp / 2 : (ct + m_exp) / 2;
    if (expn > m_nf) expn = m_nf;
    m_exp = expn;
    acc_exp = (ct >= expn) && (nw > 0);
    if (acc_exp) begin
      foreach (seen[i]) if (seen[i]) m_at[i] = 1'b1;
      m_total += nw;
    end
    m_utc++;
    cov_exp = (m_total * 100) >= (m_cov * m_nf);
    fin = cov_exp || (m_utc == m_ut);

    acc_cnt = 0; accd = '0;
    repeat (3) begin
      step();
      if (o_av) begin acc_cnt++; accd = o_ad; end
    end
    $display("[TB] dut=%0d vec=%02h ct=%0d nw=%0d exp=%0d acc=%0d total=%0d ut=%0d",
             sel, vec, ct, nw, expn, acc_exp, m_total, m_utc);
    tests_run++;
    if (acc_cnt !== (acc_exp ? 1 : 0)) begin
      tests_failed++;
      $display("FAIL acc_pulses got %0d want %0d", acc_cnt, acc_exp ? 1 : 0);
    end
    if (acc_exp) begin
      tests_run++;
      if (accd !== vec) begin
        tests_failed++;
        $display("FAIL acc_data got %02h want %02h", accd, vec);
      end
    end
    tests_run++;
    if (o_tot !== m_total || o_ut !== m_utc) begin
      tests_failed++;
      $display("FAIL counters got total=%0d ut=%0d want total=%0d ut=%0d", o_tot, o_ut, m_total, m_utc);
    end
    tests_run++;
    if (o_done !== fin || o_busy !== !fin || o_cov !== cov_exp) begin
      tests_failed++;
      $display("FAIL status got done=%0b busy=%0b cov=%0b want done=%0b busy=%0b cov=%0b",
               o_done, o_busy, o_cov, fin, !fin, cov_exp);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    tests_run++;
    if ({a_vv, a_av, a_busy, a_done, a_cov, a_ut, a_tot} !== '0) begin
      tests_failed++;
      $display("FAIL reset_a got %0b%0b%0b%0b%0b ut=%0d tot=%0d want all 0",
               a_vv, a_av, a_busy, a_done, a_cov, a_ut, a_tot);
    end
    tests_run++;
    if ({b_vv, b_av, b_busy, b_done, b_cov, b_ut, b_tot} !== '0) begin
      tests_failed++;
      $display("FAIL reset_b got %0b%0b%0b%0b%0b ut=%0d tot=%0d want all 0",
               b_vv, b_av, b_busy, b_done, b_cov, b_ut, b_tot);
    end
  endtask

  task automatic test_accept_reject();
    pick(0); apply_reset(); do_start();
    tests_run++;
    if (o_vd !== 8'h01) begin
      tests_failed++;
      $display("FAIL first_vec got %02h want 01", o_vd);
    end
    bq.delete(); bq.push_back(3); bq.push_back(7); bq.push_back(3); bq.push_back(0); bq.push_back(1475);
    do_vector(5);
    tests_run++;
    if (o_tot !== 2) begin tests_failed++; $display("FAIL vec1_total got %0d want 2", o_tot); end
    tests_run++;
    if (o_vd !== 8'hB8) begin tests_failed++; $display("FAIL second_vec got %02h want b8", o_vd); end
    bq.delete(); bq.push_back(3); bq.push_back(7);
    do_vector(0);
    tests_run++;
    if (o_tot !== 2) begin tests_failed++; $display("FAIL vec2_total got %0d want 2", o_tot); end
    bq.delete();
    do_vector(1);
  endtask

  task automatic test_ut_limit();
    pick(0); apply_reset(); do_start();
    bq.delete();
    repeat (3) do_vector(0);
    tests_run++;
    if (o_done !== 1'b1 || o_tot !== 0 || o_cov !== 1'b0 || o_ut !== 3) begin
      tests_failed++;
      $display("FAIL ut_limit got done=%0b tot=%0d cov=%0b ut=%0d want 1 0 0 3", o_done, o_tot, o_cov, o_ut);
    end
  endtask

  task automatic test_coverage();
    pick(1); apply_reset(); do_start();
    bq.delete(); bq.push_back(1); bq.push_back(2); bq.push_back(3);
    do_vector(0);
    tests_run++;
    if (o_tot !== 3 || o_cov !== 1'b1 || o_done !== 1'b1 || o_ut !== 1) begin
      tests_failed++;
      $display("FAIL coverage got tot=%0d cov=%0b done=%0b ut=%0d want 3 1 1 1", o_tot, o_cov, o_done, o_ut);
    end
  endtask

  task automatic test_reset_mid_run();
    int cnt;
    pick(0); apply_reset(); do_start();
    bq.delete(); bq.push_back(5);
    do_vector(0);
    cnt = 0;
    while (!o_vv && cnt < 20) begin step(); cnt++; end
    vec_ready = 1'b1; step(); vec_ready = 1'b0;
    det_valid = 1'b1; det_hit = 1'b1; det_last = 1'b0; det_index = 11'd9; step();
    det_valid = 1'b0; det_hit = 1'b0;
    rst_n = 1'b0; step();
    tests_run++;
    if (o_av !== 1'b0 || o_busy !== 1'b0 || o_vv !== 1'b0 || o_tot !== 0) begin
      tests_failed++;
      $display("FAIL mid_reset got acc=%0b busy=%0b vv=%0b tot=%0d want 0 0 0 0", o_av, o_busy, o_vv, o_tot);
    end
    step(); rst_n = 1'b1;
    m_lfsr[0] = 8'h01; m_lfsr[1] = 8'h01;
    do_start();
    bq.delete(); bq.push_back(5);
    do_vector(0);
    tests_run++;
    if (o_tot !== 1) begin tests_failed++; $display("FAIL post_reset_total got %0d want 1", o_tot); end
  endtask

  task automatic test_random(input int s, input int runs, input int max_idx);
    pick(s); apply_reset();
    for (int r = 0; r < runs; r++) begin
      do_start();
      fin = 1'b0;
      for (int v = 0; v < m_ut && !fin; v++) begin
        bq.delete();
        for (int k = 0; k < int'($urandom_range(0, 6)); k++) begin
          if ($urandom_range(0, 9) == 0) bq.push_back(int'($urandom_range(max_idx, max_idx + 2)));
          else bq.push_back(int'($urandom_range(0, 6)) - 1);
        end
        do_vector(int'($urandom_range(0, 2)));
      end
    end
  endtask

  initial begin
    test_reset();
    test_accept_reject();
    test_ut_limit();
    test_coverage();
    test_reset_mid_run();
    test_random(1, 6, 3);
    test_random(0, 3, NF_A - 1);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/rtg_controller.md
RTG_CONTROLLER -- requirements
Module: rtg_controller

Interface
REQ-001 SHALL have parameter VEC_W, default 64, meaning test-vector width.
REQ-002 SHALL have parameter POLY, default 64'hD800000000000000, meaning Galois LFSR feedback taps, VEC_W bits.
REQ-003 SHALL have parameter SEED, default 1, meaning LFSR reset value; a zero value is replaced by 1.
REQ-004 SHALL have parameter NUM_FAULTS, default 1474, meaning fault-list length; faults are indexed 1..NUM_FAULTS.
REQ-005 SHALL have parameter UT_LIMIT, default 1000, meaning the maximum number of generated vectors.
REQ-006 SHALL have parameter COV_PCT, default 99, meaning target coverage in percent.
REQ-007 SHALL have parameter INIT_EXP, default 2, meaning the initial expected-fault threshold.
REQ-008 SHALL use one clock; reset is synchronous and active-low: clk input 1, rising-edge clock; rst_n input 1, synchronous active-low reset.
REQ-009 SHALL have port start, input, 1 bit: one-cycle pulse that begins a run.
REQ-010 SHALL have port vec_valid, output, 1 bit, and port vec_data, output, VEC_W bits: vector offered to the fault-simulation harness.
REQ-011 SHALL have port vec_ready, input, 1 bit: harness accepts the offered vector.
REQ-012 SHALL have ports det_valid, input, 1 bit; det_index, input, clog2(NUM_FAULTS+1) bits; det_hit, input, 1 bit; det_last, input, 1 bit: per-fault result of the current vector.
REQ-013 SHALL have ports acc_valid, output, 1 bit, and acc_data, output, VEC_W bits: accepted-vector strobe and value.
REQ-014 SHALL have status outputs busy (1), done (1), cov_met (1), ut_count (clog2(UT_LIMIT+1)) and det_total (clog2(NUM_FAULTS+1)).

Function
REQ-015 SHALL implement states IDLE, GEN, COLLECT, EVAL, MERGE and DONE.
REQ-016 SHALL go from IDLE to GEN on start, clearing ut_count, det_total, the detected-all bitmap AT, and cov_met, and loading exp with INIT_EXP.
REQ-017 In GEN, SHALL assert vec_valid with vec_data equal to the current LFSR value and hold both stable until vec_ready is sampled high.
REQ-018 On GEN handshake: the LFSR SHALL advance one step; ut_count SHALL increment; the per-vector bitmap CT, count ct and new-count nw SHALL clear; next state SHALL be COLLECT.
REQ-019 In COLLECT, each cycle with det_valid and det_hit SHALL set CT[det_index], increment ct and, if AT[det_index] is 0, increment nw.
REQ-020 In COLLECT, an index already set in CT, index 0, or index > NUM_FAULTS SHALL be ignored.
REQ-021 In COLLECT, det_valid with det_last SHALL process that beat and then move to EVAL.
REQ-022 In EVAL, SHALL compute exp_n = exp/2 if ct < exp, else exp_n = (ct+exp)/2 (floor), and register exp <= exp_n.
REQ-023 In EVAL, SHALL accept the vector if ct >= exp_n and nw > 0, then go to MERGE; otherwise go to the stop check (REQ-025).
REQ-024 In MERGE (1 cycle), SHALL perform AT <= AT | CT and det_total <= det_total + nw, and pulse acc_valid for 1 cycle with acc_data equal to the accepted vector.
REQ-025 Stop check: cov_met SHALL equal (det_total*100 >= COV_PCT*NUM_FAULTS), using updated values, with arithmetic wide enough to avoid overflow.
REQ-026 If cov_met is set or ut_count == UT_LIMIT, SHALL go to DONE; otherwise SHALL go to GEN.
REQ-027 busy SHALL be 1 in all states except IDLE and DONE; done SHALL be 1 only in DONE.
REQ-028 DONE SHALL hold all status outputs; start in DONE SHALL restart as in REQ-016; start in any other non-IDLE state SHALL be ignored.
REQ-029 det_valid outside COLLECT SHALL be ignored.
REQ-030 exp SHALL saturate at NUM_FAULTS, and ct and nw SHALL never exceed NUM_FAULTS.

Reset
REQ-031 With rst_n low at a clock edge, SHALL enter IDLE and reset LFSR=SEED (or 1 if SEED is 0), exp=INIT_EXP, AT=0, CT=0, all counters 0, and vec_valid, acc_valid, busy, done, cov_met all 0.
REQ-032 Reset asserted mid-run (any state) SHALL abort the run without emitting acc_valid, and the next start SHALL reproduce the identical vector sequence.

Verification
REQ-033 Reset then start with SEED=1 and VEC_W=8, POLY=8'hB8 -> first vec_data=8'h01, second=8'hB8; vec_data SHALL stay stable while vec_ready is held low for 5 cycles.
REQ-034 Vector 1 with hits on indices 3, 7, 3, 0, 1475 -> ct=2, nw=2, exp 2->2, accepted; det_total=2; acc_valid pulses once.
REQ-035 Vector 2 with hits on indices 3 and 7 only -> ct=2, nw=0, exp=2, not accepted, det_total unchanged, no acc_valid.
REQ-036 NUM_FAULTS=4 and COV_PCT=75, hits {1,2,3} on the first vector -> det_total=3, cov_met=1, DONE after that vector, ut_count=1.
REQ-037 UT_LIMIT=3 with no hits -> exp sequence 1, 0, 0; done after 3 handshakes; det_total=0; cov_met=0.
REQ-038 Reset asserted during COLLECT, then start -> vec_data sequence SHALL restart from SEED, and AT SHALL be cleared.
